// File: rtl/dmux_stream.sv
// Registered 1-to-2 stream demultiplexer with one holding slot per output.
// Optional per-output delivery counters are built when DMUX_CNT_EN is defined.
module dmux_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  slot_t a_state, a_state_nxt;
  slot_t b_state, b_state_nxt;
  logic  accept_c;
  logic  load_a_c;
  logic  load_b_c;

  // Readiness looks only at the slot the current word is aimed at.
  assign in_ready = in_sel ? (!b_valid || b_ready) : (!a_valid || a_ready);
  assign accept_c = in_valid && in_ready;
  assign load_a_c = accept_c && !in_sel;
  assign load_b_c = accept_c && in_sel;

  assign a_valid = (a_state == FULL);
  assign b_valid = (b_state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state <= EMPTY;
      b_state <= EMPTY;
    end else begin
      a_state <= a_state_nxt;
      b_state <= b_state_nxt;
    end
  end

  always_comb begin
    a_state_nxt = a_state;
    b_state_nxt = b_state;
    case (a_state)
      EMPTY:   if (load_a_c) a_state_nxt = FULL;
      FULL:    if (a_ready && !load_a_c) a_state_nxt = EMPTY;
      default: a_state_nxt = EMPTY;
    endcase
    case (b_state)
      EMPTY:   if (load_b_c) b_state_nxt = FULL;
      FULL:    if (b_ready && !load_b_c) b_state_nxt = EMPTY;
      default: b_state_nxt = EMPTY;
    endcase
  end

  // Slot words change only on a load and keep their value after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (load_a_c) a_data <= in_data;
      if (load_b_c) b_data <= in_data;
    end
  end

`ifdef DMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (a_valid && a_ready) a_count <= a_count + CNT_W'(1);
      if (b_valid && b_ready) b_count <= b_count + CNT_W'(1);
    end
  end
`else
  assign a_count = '0;
  assign b_count = '0;
`endif

endmodule

// File: tb/tb_dmux_stream.sv
// Randomized and directed bench for dmux_stream against a slot-queue reference model.
module tb_dmux_stream;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  dmux_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .a_count(a_count), .b_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each slot is a queue of at most one word awaiting delivery.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] last_a, last_b;
  int               na, nb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    na = 0;
    nb = 0;
  endtask

  function automatic logic [31:0] exp_count(input int n);
`ifdef DMUX_CNT_EN
    return 32'(n % (1 << CNT_W));
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic check_outputs();
    check("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    check("a_data",  32'(a_data),  32'(last_a));
    check("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    check("b_data",  32'(b_data),  32'(last_b));
    check("a_count", 32'(a_count), exp_count(na));
    check("b_count", 32'(b_count), exp_count(nb));
  endtask

  function automatic logic model_ready(input logic s, input logic ar, input logic br);
    return s ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance model, wait next posedge+1.
  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                      input logic ar, input logic br);
    logic rdy;
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    @(negedge clk);
    rdy = model_ready(s, ar, br);
    check("in_ready", 32'(in_ready), 32'(rdy));
    check_outputs();
    if (qa.size() != 0 && ar) begin void'(qa.pop_front()); na++; end
    if (qb.size() != 0 && br) begin void'(qb.pop_front()); nb++; end
    if (v && rdy) begin
      if (s) begin qb.push_back(d); last_b = d; end
      else   begin qa.push_back(d); last_a = d; end
    end
    @(posedge clk);
    #1;
  endtask

  logic             pv, ps;
  logic [WIDTH-1:0] pd;
  logic             rar, rbr;

  initial begin
    model_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h5A5A; a_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset holds both slots empty even with a word offered.
    check("rst_a_valid", 32'(a_valid), 32'h0);
    check("rst_b_valid", 32'(b_valid), 32'h0);
    check("rst_a_data",  32'(a_data),  32'h0);
    check("rst_b_data",  32'(b_data),  32'h0);
    rst_n = 1'b1;

    // Routing to each output.
    step(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("route_a_data", 32'(last_a), 32'h1234);
    step(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Back-to-back into A with the consumer always ready.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h0100 + i), 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Isolation: A full and stalled, a B-bound word still passes.
    step(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("iso_a_held", 32'(a_data), 32'h7777);
    check("iso_b_data", 32'(b_data), 32'h00FF);

    // Stall then drain+refill on A.
    step(1'b1, 1'b0, 16'h8888, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h8888, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("refill_a_data", 32'(a_data), 32'h8888);

    // Reset in mid-transfer clears valids immediately.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_a_valid", 32'(a_valid), 32'h0);
    check("midrst_b_valid", 32'(b_valid), 32'h0);
    check("midrst_a_data",  32'(a_data),  32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 257 deliveries on A to exercise counter wrap.
    for (int i = 0; i < 257; i++) step(1'b1, 1'b0, 16'(i * 3), 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("wrap_a_count", 32'(a_count), exp_count(257));
    check("wrap_b_count", 32'(b_count), 32'h0);

    // Randomized traffic with a producer that holds its word until accepted.
    pv = 1'b0; ps = 1'b0; pd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv) begin
        pv = ($urandom % 4) != 0;
        ps = 1'($urandom);
        pd = 16'($urandom);
      end
      rar = ($urandom % 3) != 0;
      rbr = ($urandom % 3) != 0;
      if (pv && model_ready(ps, rar, rbr)) begin
        step(pv, ps, pd, rar, rbr);
        pv = 1'b0;
      end else begin
        step(pv, ps, pd, rar, rbr);
      end
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
